maxpool_2x2: RTL and testbench

MAXPOOL_2X2 -- requirements
Module: maxpool_2x2

---
 rtl/maxpool_2x2.sv | 109 ++++++++++
 tb/tb_maxpool_2x2.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/maxpool_2x2.sv
// 2x2 stride-2 signed max pooling over a raster-order pixel stream.
// Ports: i_clk, i_rst_n (async low), i_clear, i_valid/i_data in; o_valid/o_data/o_frame_done out.
module maxpool_2x2 #(
    parameter int I_W     = 16,
    parameter int IN_COLS = 28,
    parameter int IN_ROWS = 28
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic                  i_valid,
    input  logic signed [I_W-1:0] i_data,
    output logic                  o_valid,
    output logic signed [I_W-1:0] o_data,
    output logic                  o_frame_done
);

    localparam int OC = IN_COLS / 2;
    localparam int CW = $clog2(IN_COLS);
    localparam int RW = $clog2(IN_ROWS);
    localparam int LW = (OC > 1) ? $clog2(OC) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IN_COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IN_ROWS - 1);

    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic signed [I_W-1:0] hreg_q, hreg_d;
    logic                  valid_q, valid_d;
    logic signed [I_W-1:0] data_q, data_d;
    logic                  done_q, done_d;

    // Pair maxima of the even row, one per output column.
    logic signed [I_W-1:0] lbuf_q [OC];

    logic [LW-1:0]         lb_idx;
    logic                  lb_we;
    logic signed [I_W-1:0] lb_rd;
    logic signed [I_W-1:0] pair_max;
    logic signed [I_W-1:0] pool_max;

    always_comb begin
        lb_idx   = LW'(col_q >> 1);
        lb_rd    = lbuf_q[lb_idx];
        pair_max = (i_data > hreg_q) ? i_data : hreg_q;
        pool_max = (lb_rd > pair_max) ? lb_rd : pair_max;

        col_d   = col_q;
        row_d   = row_q;
        hreg_d  = hreg_q;
        valid_d = 1'b0;
        data_d  = data_q;
        done_d  = 1'b0;
        lb_we   = 1'b0;

        // Clear takes priority and discards any pixel offered with it.
        if (i_clear) begin
            col_d  = '0;
            row_d  = '0;
            hreg_d = '0;
        end else if (i_valid) begin
            if (!col_q[0]) begin
                hreg_d = i_data;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                valid_d = 1'b1;
                data_d  = pool_max;
                done_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
            end

            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            hreg_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            hreg_q  <= hreg_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    // Every entry is rewritten on an even row before it is read.
    always_ff @(posedge i_clk) begin
        if (lb_we) begin
            lbuf_q[lb_idx] <= pair_max;
        end
    end

    assign o_valid      = valid_q;
    assign o_data       = data_q;
    assign o_frame_done = done_q;

endmodule

// File: tb/tb_maxpool_2x2.sv
// Randomized bench for maxpool_2x2 against a frame-array reference model.
// Model: each completed 2x2 block yields max of its four stored pixels.
module tb_maxpool_2x2;

    localparam int W  = 16;
    localparam int C  = 28;
    localparam int R  = 28;
    localparam int N  = C * R;
    localparam int NO = N / 4;

    logic                i_clk   = 1'b0;
    logic                i_rst_n = 1'b0;
    logic                i_clear = 1'b0;
    logic                i_valid = 1'b0;
    logic signed [W-1:0] i_data  = '0;
    logic                o_valid;
    logic signed [W-1:0] o_data;
    logic                o_frame_done;

    maxpool_2x2 #(.I_W(W), .IN_COLS(C), .IN_ROWS(R)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (i_clear),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .o_frame_done (o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_pass = 0;
    int pix[N];
    int fr[N];
    int pidx     = 0;
    int last_out = 0;
    int outq[$];
    int ref_q[$];
    int dcnt = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One clock: drive inputs, advance model, sample 1 time unit after edge.
    task automatic step(input logic v, input int d, input logic clr);
        bit ev = 0;
        bit ed = 0;
        int ex = last_out;
        int r, c;
        i_valid = v;
        i_data  = W'(d);
        i_clear = clr;
        if (clr) begin
            pidx = 0;
        end else if (v) begin
            pix[pidx] = d;
            r = pidx / C;
            c = pidx % C;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                ev = 1;
                ex = mx(mx(pix[(r-1)*C + c-1], pix[(r-1)*C + c]),
                        mx(pix[r*C + c-1], pix[r*C + c]));
                ed = (pidx == N - 1);
            end
            pidx = (pidx + 1) % N;
        end
        @(posedge i_clk);
        #1;
        check("o_valid", o_valid, ev);
        check("o_frame_done", o_frame_done, ed);
        check("o_data", o_data, ex);
        if (o_valid) outq.push_back(int'(o_data));
        if (o_frame_done) dcnt++;
        last_out = ex;
    endtask

    task automatic run_frame(input int gap);
        for (int i = 0; i < N; i++) begin
            while ($urandom_range(99) < gap) step(1'b0, int'($urandom_range(65535)) - 32768, 1'b0);
            step(1'b1, fr[i], 1'b0);
        end
    endtask

    task automatic ramp();
        for (int i = 0; i < N; i++) fr[i] = i;
    endtask

    task automatic cmp_ref(input string tag);
        check({tag, "_n"}, outq.size(), NO);
        for (int i = 0; i < NO; i++) check(tag, outq[i], ref_q[i]);
    endtask

    initial begin
        #2;
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_done", o_frame_done, 0);
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        // Continuous ramp frame.
        ramp();
        outq.delete();
        dcnt = 0;
        run_frame(0);
        check("ramp_n", outq.size(), NO);
        check("ramp_first", outq[0], 29);
        check("ramp_second", outq[1], 31);
        check("ramp_last", outq[NO-1], 783);
        check("ramp_dones", dcnt, 1);
        ref_q = outq;

        // Signed compare: one -1 among -5.
        for (int i = 0; i < N; i++) fr[i] = -5;
        fr[3*C + 6] = -1;
        outq.delete();
        run_frame(0);
        check("neg_hit", outq[1*(C/2) + 3], -1);
        check("neg_other", outq[0], -5);

        // Ramp with idle cycles.
        ramp();
        outq.delete();
        run_frame(50);
        cmp_ref("gap_seq");

        // Clear mid-frame, with a valid pixel offered alongside clear.
        for (int i = 0; i < 100; i++) step(1'b1, int'($urandom_range(65535)) - 32768, 1'b0);
        step(1'b1, 12345, 1'b1);
        outq.delete();
        dcnt = 0;
        run_frame(0);
        cmp_ref("clr_seq");
        check("clr_dones", dcnt, 1);

        // Reset at pixel (13,9).
        for (int i = 0; i < 13*C + 9; i++) step(1'b1, int'($urandom_range(65535)) - 32768, 1'b0);
        #3;
        i_valid = 1'b1;
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_data", o_data, 0);
        check("mid_rst_done", o_frame_done, 0);
        @(posedge i_clk);
        #1;
        check("mid_rst_valid2", o_valid, 0);
        i_valid = 1'b0;
        i_rst_n = 1'b1;
        pidx = 0;
        last_out = 0;
        outq.delete();
        dcnt = 0;
        run_frame(0);
        cmp_ref("rst_seq");

        // Two random frames back to back.
        for (int i = 0; i < N; i++) fr[i] = int'($urandom_range(65535)) - 32768;
        outq.delete();
        dcnt = 0;
        run_frame(0);
        run_frame(0);
        check("b2b_n", outq.size(), 2*NO);
        check("b2b_dones", dcnt, 2);
        for (int i = 0; i < NO; i++) check("b2b_repeat", outq[i+NO], outq[i]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
